// File: rtl/ftdi_tx_arbiter.sv
// ftdi_tx_arbiter
// Round-robin arbiter sharing the FTDI transmit word interface among four
// requesters. One 32-bit word is issued per SEND cycle, followed by a blanking
// HOLD cycle (while the transmitter's registered busy flag catches up) and a
// WAIT cycle that holds until the transmitter is free. A granted requester may
// keep the interface for up to MAX_BURST consecutive words.
module ftdi_tx_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic         clock,
  input  logic         extReset,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  input  logic [15:0]  req_valid,
  output logic [3:0]   ack,
  output logic [3:0]   grant,
  output logic         send,
  output logic [31:0]  send_data,
  output logic [3:0]   send_valid,
  input  logic         tx_busy,
  output logic         active
);

  // Highest burst_cnt value that still allows one more word in the burst.
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  last;
  logic [1:0]  last_nxt;
  logic [7:0]  burst_cnt;
  logic [7:0]  burst_nxt;
  logic [3:0]  grant_nxt;
  logic [31:0] data_nxt;
  logic [3:0]  valid_nxt;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  g_idx;
  logic        owner_req;

  // First requester found scanning last+1, last+2, ... modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!res[2] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Index of the one-hot grant owner.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (oh[k]) begin
        idx = 2'(k);
      end
    end
    return idx;
  endfunction

  // Word slice of requester i.
  function automatic logic [31:0] data_slice(input logic [127:0] d, input logic [1:0] i);
    return d[{i, 5'b00000} +: 32];
  endfunction

  // Byte-enable slice of requester i.
  function automatic logic [3:0] valid_slice(input logic [15:0] v, input logic [1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

  // Arbitration helpers derived from the current request and owner.
  always_comb begin
    {win_found, win_idx} = rr_pick(req, last);
    g_idx                = onehot_idx(grant);
    owner_req            = |(req & grant);
  end

  // Next-state and next-register values.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    burst_nxt = burst_cnt;
    grant_nxt = grant;
    data_nxt  = send_data;
    valid_nxt = send_valid;
    case (state)
      IDLE: begin
        if (!tx_busy && win_found) begin
          grant_nxt = 4'(1) << win_idx;
          data_nxt  = data_slice(req_data, win_idx);
          valid_nxt = valid_slice(req_valid, win_idx);
          burst_nxt = 8'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        // tx_busy is not yet valid for the word just sent.
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          if (owner_req && (burst_cnt < BURST_LIMIT)) begin
            data_nxt  = data_slice(req_data, g_idx);
            valid_nxt = valid_slice(req_valid, g_idx);
            burst_nxt = burst_cnt + 8'd1;
            state_nxt = SEND;
          end else begin
            last_nxt  = g_idx;
            grant_nxt = 4'b0000;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state      <= IDLE;
      last       <= 2'd3;
      burst_cnt  <= 8'd0;
      grant      <= 4'b0000;
      send_data  <= 32'd0;
      send_valid <= 4'b0000;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      burst_cnt  <= burst_nxt;
      grant      <= grant_nxt;
      send_data  <= data_nxt;
      send_valid <= valid_nxt;
    end
  end

  // Strobes decoded from state so they clear as soon as reset hits.
  always_comb begin
    send   = (state == SEND);
    ack    = (state == SEND) ? grant : 4'b0000;
    active = (state != IDLE);
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed bench for ftdi_tx_arbiter: one instance at MAX_BURST=16 and one at
// MAX_BURST=2 share clock, reset and requester inputs.
module tb_ftdi_tx_arbiter;

  logic         clock;
  logic         extReset;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [15:0]  req_valid;
  logic         tx_busy;

  logic [3:0]   a_ack, a_grant, a_send_valid;
  logic         a_send, a_active;
  logic [31:0]  a_send_data;
  logic [3:0]   b_ack, b_grant, b_send_valid;
  logic         b_send, b_active;
  logic [31:0]  b_send_data;

  int pass_cnt = 0;
  int total    = 0;

  ftdi_tx_arbiter #(.MAX_BURST(16)) dut_a (
    .clock(clock), .extReset(extReset), .req(req), .req_data(req_data),
    .req_valid(req_valid), .ack(a_ack), .grant(a_grant), .send(a_send),
    .send_data(a_send_data), .send_valid(a_send_valid), .tx_busy(tx_busy),
    .active(a_active)
  );

  ftdi_tx_arbiter #(.MAX_BURST(2)) dut_b (
    .clock(clock), .extReset(extReset), .req(req), .req_data(req_data),
    .req_valid(req_valid), .ack(b_ack), .grant(b_grant), .send(b_send),
    .send_data(b_send_data), .send_valid(b_send_valid), .tx_busy(tx_busy),
    .active(b_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    total++;
    $error("FAIL %s: timed out waiting for send", tag);
  endtask

  initial begin
    logic [3:0] seq_q[$];
    logic [3:0] exp_rr [10];
    logic [3:0] exp_er [4];
    int         n1;
    int         cyc;
    bit         got;

    exp_rr = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
               4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    exp_er = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};

    extReset  = 1'b1;
    req       = 4'hF;
    tx_busy   = 1'b0;
    req_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h534C4131};
    req_valid = {4'h8, 4'h0, 4'h3, 4'hF};

    // Reset held for 3 cycles with all requesters asking.
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_send", 32'(a_send), 32'd0);
      chk("rst_ack", 32'(a_ack), 32'd0);
      chk("rst_grant", 32'(a_grant), 32'd0);
      chk("rst_active", 32'(a_active), 32'd0);
      chk("rst_b_grant", 32'(b_grant), 32'd0);
      step();
    end
    chk("rst_data", a_send_data, 32'd0);
    chk("rst_valid", 32'(a_send_valid), 32'd0);
    extReset = 1'b0;
    step();
    chk("first_grant", 32'(a_grant), 32'h1);
    chk("first_send", 32'(a_send), 32'd1);
    chk("first_b_grant", 32'(b_grant), 32'h1);
    req = 4'h0;
    for (int i = 0; i < 4; i++) step();
    chk("first_idle", 32'(a_grant), 32'd0);

    // Single word with a transmitter busy window of 8 cycles.
    req = 4'b0001;
    step();
    chk("sw_send", 32'(a_send), 32'd1);
    chk("sw_ack", 32'(a_ack), 32'b0001);
    chk("sw_data", a_send_data, 32'h534C4131);
    chk("sw_valid", 32'(a_send_valid), 32'hF);
    req = 4'h0;
    step();
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("sw_busy_nosend", 32'(a_send), 32'd0);
    end
    chk("sw_grant_held", 32'(a_grant), 32'b0001);
    tx_busy = 1'b0;
    step();
    chk("sw_grant_clear", 32'(a_grant), 32'd0);
    chk("sw_active_clear", 32'(a_active), 32'd0);
    step();

    // Busy blocking in IDLE with requester 2 waiting.
    tx_busy = 1'b1;
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bb_nosend", 32'(a_send), 32'd0);
      chk("bb_nogrant", 32'(a_grant), 32'd0);
    end
    tx_busy = 1'b0;
    step();
    chk("bb_send", 32'(a_send), 32'd1);
    chk("bb_grant", 32'(a_grant), 32'b0100);
    chk("bb_ack", 32'(a_ack), 32'b0100);
    chk("bb_data", a_send_data, 32'h22222222);
    chk("bb_valid_zero", 32'(a_send_valid), 32'h0);
    req = 4'h0;
    for (int i = 0; i < 4; i++) step();

    // Early release: requester 1 drops after 3 acks, requester 3 waiting.
    req = 4'b0010;
    n1 = 0;
    got = 1'b0;
    seq_q.delete();
    for (cyc = 0; cyc < 100 && !got; cyc++) begin
      step();
      if (a_send) begin
        seq_q.push_back(a_grant);
        req[3] = 1'b1;
        if (a_ack[1]) begin
          n1++;
          if (n1 == 3) req[1] = 1'b0;
        end
        if (a_ack[3]) begin
          req = 4'h0;
          got = 1'b1;
        end
      end
    end
    if (!got) timeout("er_wait");
    chk("er_count", 32'(seq_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < seq_q.size()) chk($sformatf("er_grant%0d", i), 32'(seq_q[i]), 32'(exp_er[i]));
    end
    for (int i = 0; i < 4; i++) step();

    // Reset mid-burst while in WAIT, then round-robin at MAX_BURST=2.
    req = 4'b0110;
    got = 1'b0;
    for (cyc = 0; cyc < 20 && !got; cyc++) begin
      step();
      if (a_send) got = 1'b1;
    end
    if (!got) timeout("mr_wait");
    chk("mr_pre_grant", 32'(a_grant), 32'b0010);
    step();
    step();
    extReset = 1'b1;
    req = 4'hF;
    #1;
    chk("mr_send", 32'(a_send), 32'd0);
    chk("mr_grant", 32'(a_grant), 32'd0);
    chk("mr_active", 32'(a_active), 32'd0);
    chk("mr_data", a_send_data, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mr_hold_send", 32'(a_send), 32'd0);
      chk("mr_hold_ack", 32'(a_ack), 32'd0);
    end
    extReset = 1'b0;
    seq_q.delete();
    for (cyc = 0; cyc < 100 && seq_q.size() < 10; cyc++) begin
      step();
      if (cyc == 0) chk("mr_after_grant", 32'(a_grant), 32'b0001);
      if (b_send) begin
        chk("rr_ack", 32'(b_ack), 32'(exp_rr[seq_q.size()]));
        seq_q.push_back(b_grant);
      end
    end
    if (seq_q.size() < 10) timeout("rr_wait");
    for (int i = 0; i < 10; i++) begin
      if (i < seq_q.size()) chk($sformatf("rr_grant%0d", i), 32'(seq_q[i]), 32'(exp_rr[i]));
    end
    req = 4'h0;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
# ftdi_tx_arbiter

Round-robin arbiter that shares the FTDI transmit word interface (`send`/`send_data`/`send_valid`/`busy`) among four requesters, e.g. the sample readback engine, status reporter and debug taps. It sits between the requesters and the FTDI async FIFO transmitter. It issues one 32-bit word at a time, never while the transmitter is busy. A requester may keep its grant for a bounded burst of words before the grant rotates.

## Interface
- `MAX_BURST`, default 16: maximum consecutive words per grant; legal range 1..256.
- `clock` in 1: system clock; all logic on rising edge.
- `extReset` in 1: reset, asynchronous, active-high.
- `req` in 4: per-requester word-ready; `req[i]` is level-held until `ack[i]`.
- `req_data` in 128: requester i word at `[32i+31:32i]`; stable while `req[i]`=1.
- `req_valid` in 16: requester i byte enables at `[4i+3:4i]`; stable while `req[i]`=1.
- `ack` out 4: one-cycle pulse; word of requester i accepted.
- `grant` out 4: one-hot current owner; 0 when idle.
- `send` out 1: one-cycle strobe to the transmitter.
- `send_data` out 32: word to the transmitter, registered.
- `send_valid` out 4: byte enables to the transmitter, registered.
- `tx_busy` in 1: transmitter busy; registered in the transmitter, so it is valid one cycle after `send`.
- `active` out 1: high whenever state is not IDLE.

## Operation
- **States:**
  - IDLE: no grant.
  - SEND: `send`=1 and `ack[g]`=1 for exactly this cycle.
  - HOLD: blanking cycle; `tx_busy` is ignored.
  - WAIT: waits for `tx_busy`=0.
- **Registers:**
  - `state`.
  - 2-bit round-robin pointer `last`; reset 3, so requester 0 wins first.
  - 8-bit `burst_cnt`.
  - `grant`, `send_data`, `send_valid`.
- **IDLE**, when `tx_busy`=0 and `|req`:
  - Winner g is the first set `req` bit searching `last+1`, `last+2`, … modulo 4.
  - Register `grant`=1<<g; latch `req_data`/`req_valid` slice g into `send_data`/`send_valid`.
  - Set `burst_cnt`=0; go to SEND.
- **IDLE**, when `tx_busy`=1: no arbitration, no outputs change.
- **SEND → HOLD** unconditionally.
- **HOLD → WAIT** unconditionally.
- **WAIT**, when `tx_busy`=0:
  - If `req[g]`=1 and `burst_cnt` < `MAX_BURST`-1: relatch slice g, increment `burst_cnt`, go to SEND with grant kept.
  - Otherwise: set `last`=g, `grant`=0, go to IDLE.
- **WAIT**, when `tx_busy`=1: stay.
- **Byte enables:** `req_valid`=0 is forwarded unmodified; the word is still sent and acked.
- **Requester drops `req[g]`** during HOLD/WAIT: burst ends at the next WAIT exit. The in-flight word is already acked.
- **Non-granted requests:** wait; there is no pre-emption.
- **Burst counting:** `MAX_BURST`=1 rotates after every word. Counter compare is unsigned 8-bit.
- **Reset mid-operation:** all registers return to reset values immediately. No `send`/`ack` pulse is emitted during or after reset. An in-flight word is discarded.

## Timing
- **Reset values:**
  - `send`=0, `ack`=0, `grant`=0.
  - `send_data`=0, `send_valid`=0.
  - `active`=0.
- **Latency:** `req` seen in IDLE at cycle t with `tx_busy`=0 gives `send`=1, `ack[g]`=1 and `grant` valid at t+1.
- **`ack[g]` and `send`** are coincident; the requester may change its data or deassert from t+2.
- **Minimum spacing between `send` pulses:** 3 cycles (SEND, HOLD, WAIT with `tx_busy` already low).
- **Re-arbitration after a burst ends:** WAIT exit at cycle w gives IDLE at w+1 and the next `send` at w+2.
- **`send` is never asserted** in a cycle where the preceding registered `tx_busy` was 1.

## Test plan
- **Reset:**
  - Stimulus: hold `extReset` for 3 cycles with `req`=4'hF.
  - Required: `send`/`ack`/`grant`/`active`=0 throughout; after release, the first grant is 4'b0001.
- **Single word:**
  - Stimulus: `req`=4'b0001, data 32'h534C4131, valid 4'hF; transmitter model raises `tx_busy` 1 cycle after `send` for 8 cycles.
  - Required: `send` and `ack[0]` one cycle after `req`; `send_data`=32'h534C4131; `grant` returns to 0 after `tx_busy` falls.
- **Round-robin with bursts:**
  - Stimulus: `MAX_BURST`=2, all four requesters hold `req` continuously.
  - Required: grant sequence 0,0,1,1,2,2,3,3,0,0; exactly one `ack` per `send`.
- **Busy blocking:**
  - Stimulus: `tx_busy` forced high for 20 cycles in IDLE with `req`=4'b0100.
  - Required: no `send` during those cycles; `send` with `grant`=4'b0100 one cycle after `tx_busy` falls.
- **Early release:**
  - Stimulus: `MAX_BURST`=16; requester 1 drops `req` after 3 acks while requester 3 is waiting.
  - Required: 3 words from requester 1, then `grant`=4'b1000.
- **Reset mid-burst:**
  - Stimulus: assert `extReset` during WAIT.
  - Required: outputs clear the same cycle; after release, requester 0 is served first.
